i2c_init_seq: RTL

- Power-up configuration sequencer that sits directly upstream of the I2C bus master.
- Walks a fixed table of {register, value} pairs and hands the master one register-write command per transaction.
- Uses a valid/ready/done handshake, paces messages with an inter-message delay, and retries NACKed writes.
- Reports completion or failure to the HDMI top level.

---
 rtl/i2c_init_seq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_init_seq.sv
// Power-up configuration sequencer: walks a fixed {register, value} table and
// hands the I2C master one write per transaction, with pacing and NACK retries.
module i2c_init_seq #(
    parameter logic [6:0] DEV_ADDR           = 7'h39,
    parameter int         NUM_WRITES         = 12,
    parameter int         POWERUP_DELAY      = 250_000,
    parameter int         INTERMESSAGE_DELAY = 100_000,
    parameter int         MAX_RETRIES        = 3
) (
    input  logic       sda_clk,
    input  logic       reset_n,
    input  logic       restart,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [6:0] cmd_dev_addr,
    output logic [7:0] cmd_reg,
    output logic [7:0] cmd_data,
    input  logic       cmd_done,
    input  logic       cmd_nack,
    output logic       busy,
    output logic       init_done,
    output logic       init_error,
    output logic [3:0] err_index
);

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } state_e;

    localparam logic [19:0] PU_LAST   = 20'(POWERUP_DELAY - 1);
    localparam logic [19:0] GAP_LAST  = 20'(INTERMESSAGE_DELAY - 1);
    localparam logic [3:0]  LAST_IDX  = 4'(NUM_WRITES - 1);
    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRIES);

    state_e      state_q;
    logic [19:0] cnt_q;
    logic [3:0]  index_q;
    logic [7:0]  retry_q;
    logic        adv_q;
    logic        cmd_valid_q;
    logic [7:0]  cmd_reg_q;
    logic [7:0]  cmd_data_q;
    logic        busy_q;
    logic        init_done_q;
    logic        init_error_q;
    logic [3:0]  err_index_q;
    logic [15:0] entry_d;

    function automatic logic [15:0] table_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    return 16'h4110;
            4'd1:    return 16'h9803;
            4'd2:    return 16'h9AE0;
            4'd3:    return 16'h9C30;
            4'd4:    return 16'h9D61;
            4'd5:    return 16'hA2A4;
            4'd6:    return 16'hA3A4;
            4'd7:    return 16'hE0D0;
            4'd8:    return 16'hF900;
            4'd9:    return 16'h1500;
            4'd10:   return 16'h1630;
            4'd11:   return 16'hAF06;
            default: return 16'h0000;
        endcase
    endfunction

    assign entry_d = table_entry(index_q);

    always_ff @(posedge sda_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_POWERUP;
            cnt_q        <= '0;
            index_q      <= '0;
            retry_q      <= '0;
            adv_q        <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_reg_q    <= '0;
            cmd_data_q   <= '0;
            busy_q       <= 1'b1;
            init_done_q  <= 1'b0;
            init_error_q <= 1'b0;
            err_index_q  <= '0;
        end else begin
            case (state_q)
                ST_POWERUP: begin
                    if (cnt_q == PU_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_ISSUE;
                    end else begin
                        cnt_q <= cnt_q + 20'd1;
                    end
                end
                // First ISSUE cycle latches the entry; it stays put until accepted.
                ST_ISSUE: begin
                    if (!cmd_valid_q) begin
                        cmd_valid_q <= 1'b1;
                        cmd_reg_q   <= entry_d[15:8];
                        cmd_data_q  <= entry_d[7:0];
                    end else if (cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (cmd_done) begin
                        cnt_q <= '0;
                        if (!cmd_nack) begin
                            retry_q <= '0;
                            adv_q   <= 1'b1;
                            state_q <= ST_GAP;
                        end else if (retry_q < RETRY_MAX) begin
                            retry_q <= retry_q + 8'd1;
                            adv_q   <= 1'b0;
                            state_q <= ST_GAP;
                        end else begin
                            err_index_q  <= index_q;
                            init_error_q <= 1'b1;
                            busy_q       <= 1'b0;
                            state_q      <= ST_ERROR;
                        end
                    end
                end
                // adv_q is clear after a NACK or a restart, so the same index is re-issued.
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q <= '0;
                        if (adv_q && (index_q == LAST_IDX)) begin
                            init_done_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= ST_DONE;
                        end else begin
                            if (adv_q) begin
                                index_q <= index_q + 4'd1;
                            end
                            state_q <= ST_ISSUE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 20'd1;
                    end
                end
                ST_DONE: begin
                    if (restart) begin
                        init_done_q <= 1'b0;
                        index_q     <= '0;
                        adv_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= ST_GAP;
                    end
                end
                ST_ERROR: begin
                    if (restart) begin
                        init_error_q <= 1'b0;
                        err_index_q  <= '0;
                        index_q      <= '0;
                        retry_q      <= '0;
                        adv_q        <= 1'b0;
                        busy_q       <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= ST_GAP;
                    end
                end
                default: state_q <= ST_POWERUP;
            endcase
        end
    end

    assign cmd_valid    = cmd_valid_q;
    assign cmd_dev_addr = DEV_ADDR;
    assign cmd_reg      = cmd_reg_q;
    assign cmd_data     = cmd_data_q;
    assign busy         = busy_q;
    assign init_done    = init_done_q;
    assign init_error   = init_error_q;
    assign err_index    = err_index_q;

endmodule
